seg_page_scheduler: RTL and testbench
=====================================

# seg_page_scheduler

Time-shares the 8-digit hex display driver between four requesters. Each requester offers a 32-bit value; the block rotates through the valid ones on a dwell timer and supports a timed alert override. A requester can also freeze the rotation. The registered `load` output feeds the display decoder's 32-bit `load` input directly.

## Interface
Parameters:
- `DWELL_CYCLES`, default 50_000_000: cycles each page is shown in rotation (1 s at 50 MHz); legal range ≥ 2.
- `ALERT_CYCLES`, default 150_000_000: cycles an alert page is held; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset; all state clears while low.
- `req_valid`  in  4  bit i = requester i has displayable data.
- `req_data`  in  128  requester i value at bits [32i+31:32i].
- `req_alert`  in  4  single-cycle pulse; bit i requests an override to page i.
- `hold`  in  1  level; freezes the dwell timer in ROTATE.
- `load`  out  32  value to display; registered.
- `cur_page`  out  2  index of the page being shown; registered.
- `load_valid`  out  1  1 = `load` holds requester data; 0 = idle, `load` = 0.
- `alert_active`  out  1  1 while in ALERT.

## Operation
- States: IDLE, ROTATE, ALERT. Reset state is IDLE. Reset values: `load`=0, `cur_page`=0, `load_valid`=0, `alert_active`=0, timer=0.
- Valid alert: `req_alert[i] & req_valid[i]`. Alerts on invalid requesters are ignored.
- Simultaneous events: the lowest index wins. Priority order is valid alert > current page invalid > dwell expiry.
- IDLE:
  - `req_valid` = 0 → stay in IDLE.
  - Any valid alert → ALERT on that page.
  - Otherwise → ROTATE on the lowest valid index. Timer = 0.
- ROTATE: timer increments each cycle unless `hold` = 1.
  - Timer reaches `DWELL_CYCLES-1` → advance to the next valid index after `cur_page` in round-robin order (3 wraps to 0). Timer = 0.
  - If `cur_page` is the only valid page, the page stays and the timer restarts.
  - `req_valid[cur_page]` drops → advance on the next edge regardless of `hold`. Timer = 0.
  - All `req_valid` = 0 → IDLE.
- ALERT: timer counts to `ALERT_CYCLES-1`; `hold` is ignored.
  - On expiry → ROTATE on the same page. Timer = 0.
  - A new valid alert restarts the timer on its page, including a re-alert of the same page.
  - `req_valid[cur_page]` drops → ROTATE on the next valid page, or IDLE if none are valid.
- Data:
  - Each cycle, `load` <= `req_data` slice of the next-state page, and `load_valid` <= 1, when the next state is not IDLE.
  - When the next state is IDLE, `load` <= 0 and `load_valid` <= 0.
  - Requester data changes propagate live while a page is shown.
- Timer: 32-bit unsigned. Comparisons use the parameter minus 1. The timer never wraps past the compare value.

## Timing
- `load`, `cur_page`, `load_valid` and `alert_active` all update on the same `clk` edge. There is never a cycle where `cur_page` and `load` disagree.
- Latency is 1 cycle in each of these cases:
  - from `req_data` change to `load`;
  - from a `req_alert` pulse to `cur_page`/`alert_active`;
  - from a `req_valid` drop to the page change.
- With `hold` = 0 and more than one valid page, each page is shown for exactly `DWELL_CYCLES` cycles.
- An alert page is shown for exactly `ALERT_CYCLES` cycles, then for a further full `DWELL_CYCLES` in ROTATE.
- Reset asserted mid-operation: outputs go to their reset values immediately, without waiting for a clock edge. After release, the first edge evaluates the IDLE transitions.

## Test plan
Bench parameters: `DWELL_CYCLES`=4, `ALERT_CYCLES`=10.
- Reset/idle: hold `reset`=0, then release with `req_valid`=0 → `load`=0, `load_valid`=0 and `cur_page`=0 for 20 cycles.
- Rotation: `req_valid`=4'b1011, data i = 32'h1111_1111×(i+1).
  - Required page sequence: 0,1,3,0, each shown for 4 cycles.
  - The `load` sequence is the matching data value for each page.
- Hold and drop:
  - Raise `hold` on page 1 for 12 cycles → page 1 stays.
  - Drop `req_valid[1]` while `hold` = 1 → the next edge shows page 3.
  - Drop all valids → IDLE, `load`=0.
- Alert:
  - Pulse `req_alert`=4'b0100 with page 2 valid while rotating on page 0 → next edge `cur_page`=2 and `alert_active`=1 for 10 cycles, then ROTATE on page 2 for 4 cycles, then page 3.
  - Pulse `req_alert`=4'b0110 → page 1 wins.
- Ignored alert: pulse `req_alert[3]` with `req_valid[3]`=0 → no change in `cur_page` or the timer.
- Async reset mid-ALERT: pull `reset` low between edges → all outputs are 0 before the next `clk` edge.

Source files
------------

// File: rtl/seg_page_scheduler_if.sv
// Display-page scheduler bus: four requesters in, one display page out.
// Carries no state; timing is set entirely by the scheduler.
// No backpressure: the display side always accepts the registered page.
interface seg_page_scheduler_if;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_alert;
   logic         hold;
   logic [31:0]  load;
   logic [1:0]   cur_page;
   logic         load_valid;
   logic         alert_active;

   // Requester side: offers pages, alerts and the hold level.
   modport master (
      output req_valid, req_data, req_alert, hold,
      input  load, cur_page, load_valid, alert_active
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_data, req_alert, hold,
      output load, cur_page, load_valid, alert_active
   );
endinterface

// File: rtl/seg_page_scheduler.sv
// Time-shares one 32-bit display among four requesters (rotate / alert override / hold).
// Latency: 1 cycle from any input change to load/cur_page/load_valid/alert_active.
// No backpressure: requesters are sampled every cycle, display always accepts.
module seg_page_scheduler #(
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int unsigned ALERT_CYCLES = 150_000_000
) (
   input  logic                clk,
   input  logic                reset,
   seg_page_scheduler_if.slave bus
);

   localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
   localparam logic [31:0] ALERT_LAST = 32'(ALERT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ROTATE, ST_ALERT} state_t;

   state_t      state_q, state_d;
   logic [1:0]  page_q, page_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] load_q, load_d;
   logic        load_valid_q;
   logic        alert_active_q;
   logic [3:0]  valid_alert;

   // Lowest set index; simultaneous events resolve to the smallest requester.
   function automatic logic [1:0] lowest_idx(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

   // First valid index after p in round-robin order; falls back to p itself.
   function automatic logic [1:0] next_after(input logic [1:0] p, input logic [3:0] v);
      logic [1:0] r;
      logic [1:0] idx;
      r = p;
      for (int k = 3; k >= 1; k--) begin
         idx = p + 2'(k);
         if (v[idx]) r = idx;
      end
      return r;
   endfunction

   // Next-state decision: valid alert beats a vanished page, which beats dwell expiry.
   always_comb begin
      valid_alert = bus.req_alert & bus.req_valid;
      state_d     = state_q;
      page_d      = page_q;
      timer_d     = timer_q;
      if (valid_alert != 4'd0) begin
         state_d = ST_ALERT;
         page_d  = lowest_idx(valid_alert);
         timer_d = 32'd0;
      end else if (state_q == ST_IDLE) begin
         if (bus.req_valid != 4'd0) begin
            state_d = ST_ROTATE;
            page_d  = lowest_idx(bus.req_valid);
            timer_d = 32'd0;
         end
      end else if (bus.req_valid == 4'd0) begin
         state_d = ST_IDLE;
         page_d  = 2'd0;
         timer_d = 32'd0;
      end else if (!bus.req_valid[page_q]) begin
         state_d = ST_ROTATE;
         page_d  = next_after(page_q, bus.req_valid);
         timer_d = 32'd0;
      end else if (state_q == ST_ROTATE) begin
         if (!bus.hold) begin
            if (timer_q >= DWELL_LAST) begin
               page_d  = next_after(page_q, bus.req_valid);
               timer_d = 32'd0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
      end else begin
         // Alert hold time ignores the hold input.
         if (timer_q >= ALERT_LAST) begin
            state_d = ST_ROTATE;
            timer_d = 32'd0;
         end else begin
            timer_d = timer_q + 32'd1;
         end
      end
      // Data follows the next-state page so cur_page and load never disagree.
      load_d = (state_d != ST_IDLE) ? bus.req_data[{page_d, 5'd0} +: 32] : 32'd0;
   end

   // State, timer and all display outputs register together on one edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         page_q         <= 2'd0;
         timer_q        <= 32'd0;
         load_q         <= 32'd0;
         load_valid_q   <= 1'b0;
         alert_active_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         page_q         <= page_d;
         timer_q        <= timer_d;
         load_q         <= load_d;
         load_valid_q   <= (state_d != ST_IDLE);
         alert_active_q <= (state_d == ST_ALERT);
      end
   end

   assign bus.load         = load_q;
   assign bus.cur_page     = page_q;
   assign bus.load_valid   = load_valid_q;
   assign bus.alert_active = alert_active_q;

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Bench for seg_page_scheduler: directed vector table, async reset cases,
// then randomized traffic against a page/age reference model.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_seg_page_scheduler;

   localparam int DWELL = 4;
   localparam int ALERT = 10;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   seg_page_scheduler_if bus();

   seg_page_scheduler #(.DWELL_CYCLES(DWELL), .ALERT_CYCLES(ALERT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      logic [3:0] a;
      logic       h;
      logic [1:0] p;
      logic       aa;
      logic       lv;
   } vec_t;

   vec_t tbl[$];

   // Reference model: mode 0 idle, 1 rotate, 2 alert; age = cycles the page has been up.
   int          m_mode, m_page, m_age;
   logic [31:0] m_load;
   bit          use_model = 0;

   task automatic add(input logic [3:0] v, input logic [3:0] a, input logic h,
                      input logic [1:0] p, input logic aa, input logic lv, input int n);
      vec_t e;
      e.v = v; e.a = a; e.h = h; e.p = p; e.aa = aa; e.lv = lv;
      for (int i = 0; i < n; i++) tbl.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [1:0] p, input logic aa,
                            input logic lv, input logic [31:0] ld);
      check({tag, " cur_page"}, 32'(bus.cur_page), 32'(p));
      check({tag, " alert_active"}, 32'(bus.alert_active), 32'(aa));
      check({tag, " load_valid"}, 32'(bus.load_valid), 32'(lv));
      check({tag, " load"}, bus.load, ld);
   endtask

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic int next_valid(input int p, input logic [3:0] v);
      for (int k = 1; k <= 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
      return p;
   endfunction

   task automatic model_step();
      logic [3:0] v;
      logic [3:0] va;
      v  = bus.req_valid;
      va = bus.req_alert & v;
      if (va != 4'd0) begin
         m_mode = 2; m_page = lowest(va); m_age = 1;
      end else if (m_mode == 0) begin
         if (v != 4'd0) begin m_mode = 1; m_page = lowest(v); m_age = 1; end
      end else if (v == 4'd0) begin
         m_mode = 0; m_page = 0; m_age = 0;
      end else if (!v[m_page]) begin
         m_mode = 1; m_page = next_valid(m_page, v); m_age = 1;
      end else if (m_mode == 1) begin
         if (!bus.hold) begin
            if (m_age == DWELL) begin m_page = next_valid(m_page, v); m_age = 1; end
            else m_age++;
         end
      end else begin
         if (m_age == ALERT) begin m_mode = 1; m_age = 1; end
         else m_age++;
      end
      m_load = (m_mode != 0) ? bus.req_data[32*m_page +: 32] : 32'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (use_model) model_step();
      @(negedge clk);
   endtask

   function automatic logic [31:0] fixed_data(input logic [1:0] p);
      return 32'h1111_1111 * (32'(p) + 32'd1);
   endfunction

   initial begin
      reset         = 1'b0;
      bus.req_valid = 4'd0;
      bus.req_alert = 4'd0;
      bus.hold      = 1'b0;
      for (int i = 0; i < 4; i++) bus.req_data[32*i +: 32] = fixed_data(2'(i));

      // Reset state, before and after a few edges with reset held low.
      #1 check_out("reset t0", 2'd0, 1'b0, 1'b0, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_out("reset held", 2'd0, 1'b0, 1'b0, 32'd0);
      reset = 1'b1;

      // Idle with nothing valid.
      for (int i = 0; i < 20; i++) begin
         tick();
         check_out($sformatf("idle%0d", i), 2'd0, 1'b0, 1'b0, 32'd0);
      end

      // Rotation 0,1,3,0 over valid 1011.
      add(4'b1011, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 4);
      add(4'b1011, 4'd0, 1'b0, 2'd1, 1'b0, 1'b1, 4);
      add(4'b1011, 4'd0, 1'b0, 2'd3, 1'b0, 1'b1, 4);
      add(4'b1011, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 4);
      // Hold on page 1, drop it under hold, then drop everything.
      add(4'b1011, 4'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1);
      add(4'b1011, 4'd0, 1'b1, 2'd1, 1'b0, 1'b1, 12);
      add(4'b1001, 4'd0, 1'b1, 2'd3, 1'b0, 1'b1, 2);
      add(4'b0000, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2);
      // Alert to page 2 while rotating on page 0.
      add(4'b1111, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1);
      add(4'b1111, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 1);
      add(4'b1111, 4'd0, 1'b0, 2'd2, 1'b1, 1'b1, 9);
      add(4'b1111, 4'd0, 1'b0, 2'd2, 1'b0, 1'b1, 4);
      add(4'b1111, 4'd0, 1'b0, 2'd3, 1'b0, 1'b1, 1);
      // Two simultaneous alerts: page 1 wins; an alert on invalid page 3 changes nothing.
      add(4'b1111, 4'b0110, 1'b0, 2'd1, 1'b1, 1'b1, 1);
      add(4'b0111, 4'd0, 1'b0, 2'd1, 1'b1, 1'b1, 4);
      add(4'b0111, 4'b1000, 1'b0, 2'd1, 1'b1, 1'b1, 1);
      add(4'b0111, 4'd0, 1'b0, 2'd1, 1'b1, 1'b1, 4);
      add(4'b0111, 4'd0, 1'b0, 2'd1, 1'b0, 1'b1, 4);
      add(4'b0111, 4'd0, 1'b0, 2'd2, 1'b0, 1'b1, 1);

      foreach (tbl[i]) begin
         bus.req_valid = tbl[i].v;
         bus.req_alert = tbl[i].a;
         bus.hold      = tbl[i].h;
         tick();
         check_out($sformatf("vec%0d", i), tbl[i].p, tbl[i].aa, tbl[i].lv,
                   tbl[i].lv ? fixed_data(tbl[i].p) : 32'd0);
      end

      // Async reset in the middle of an alert.
      bus.req_valid = 4'b1111;
      bus.req_alert = 4'b0001;
      bus.hold      = 1'b0;
      tick();
      check_out("pre-reset alert", 2'd0, 1'b1, 1'b1, fixed_data(2'd0));
      bus.req_alert = 4'd0;
      tick();
      #2 reset = 1'b0;
      #1 check_out("async reset", 2'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      bus.req_valid = 4'd0;
      reset         = 1'b1;
      tick();
      check_out("post-reset idle", 2'd0, 1'b0, 1'b0, 32'd0);

      // Randomized traffic against the reference model.
      m_mode = 0; m_page = 0; m_age = 0; m_load = 32'd0;
      use_model = 1;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            for (int b = 0; b < 4; b++) bus.req_valid[b] = ($urandom_range(0, 6) != 0);
         end
         bus.req_alert = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
         if ($urandom_range(0, 9) == 0) bus.hold = ~bus.hold;
         if ($urandom_range(0, 3) == 0) bus.req_data[32*$urandom_range(0, 3) +: 32] = $urandom;
         tick();
         check_out($sformatf("rnd%0d", n), 2'(m_page), (m_mode == 2), (m_mode != 0), m_load);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
